// File: rtl/core_pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding.
package core_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/core_pipe_ctrl_lvl_max.sv
// Combinational NHOLD-way maximum of the hold levels whose request bit is set.
module core_pipe_ctrl_lvl_max #(
    parameter int NHOLD = 3,
    parameter int LVL_W = 3
) (
    input  logic [NHOLD-1:0]       hold_req,
    input  logic [NHOLD*LVL_W-1:0] hold_lvl,
    output logic [LVL_W-1:0]       lvl_max
);

    always_comb begin
        lvl_max = '0;
        for (int i = 0; i < NHOLD; i++) begin
            if (hold_req[i] && (hold_lvl[i*LVL_W +: LVL_W] > lvl_max)) begin
                lvl_max = hold_lvl[i*LVL_W +: LVL_W];
            end
        end
    end

endmodule

// File: rtl/core_pipe_ctrl.sv
// Pipeline controller: merges prioritised holds into stall/flush vectors and defers jumps taken while held.
// Optional hold watchdog enabled by defining CORE_PIPE_CTRL_WDT_EN.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_RUN   | normal operation, no jump outstanding
//  ST_PEND  | jump accepted while PC held; target waits in pend_addr
//  ST_FLUSH | post-redirect bubble cycles for multi-cycle fetch
module core_pipe_ctrl
    import core_pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NSTAGE    = 4,
    parameter int NHOLD     = 3,
    parameter int LVL_W     = 3,
    parameter int JUMP_LVL  = 2,
    parameter int FLUSH_CYC = 1,
    parameter int WDT_MAX   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_flag_in,
    input  logic [ADDR_W-1:0]      jump_addr_in,
    input  logic [NHOLD-1:0]       hold_req_in,
    input  logic [NHOLD*LVL_W-1:0] hold_lvl_in,
    output logic                   jump_flag_out,
    output logic [ADDR_W-1:0]      jump_addr_out,
    output logic [NSTAGE-1:0]      stall_out,
    output logic [NSTAGE-1:0]      flush_out,
    output logic                   hold_flag_out,
    output logic                   jump_pend_out,
    output logic                   hold_wdt_out
);

    localparam int FC_W = $clog2(FLUSH_CYC + 2);

    if (JUMP_LVL < 1 || JUMP_LVL >= NSTAGE || (2**LVL_W) <= NSTAGE || WDT_MAX < 1) begin : g_param_err
        $error("core_pipe_ctrl: illegal parameter combination");
    end

    ctrl_state_e       state;
    logic [ADDR_W-1:0] pend_addr;
    logic [FC_W-1:0]   flush_cnt;

    logic [LVL_W-1:0]  lvl_raw;
    logic [LVL_W-1:0]  lvl_sat;
    logic              held;
    logic              jump_acc;
    logic              issue;
    logic              force_flush;
    logic [NSTAGE-1:0] jump_mask;
    logic [NSTAGE-1:0] stall_base;
    logic [NSTAGE-1:0] flush_base;

    core_pipe_ctrl_lvl_max #(
        .NHOLD (NHOLD),
        .LVL_W (LVL_W)
    ) u_lvl_max (
        .hold_req (hold_req_in),
        .hold_lvl (hold_lvl_in),
        .lvl_max  (lvl_raw)
    );

    // Reset is synchronous, so every combinational path is gated to keep outputs at 0 while rst is high.
    always_comb begin
        lvl_sat = lvl_raw;
        if (rst) begin
            lvl_sat = '0;
        end else if (lvl_raw > LVL_W'(NSTAGE)) begin
            lvl_sat = LVL_W'(NSTAGE);
        end
    end

    assign held        = (lvl_sat != '0);
    assign jump_acc    = jump_flag_in & ~rst;
    assign issue       = ~held & (jump_acc | (~rst & (state == ST_PEND)));
    assign force_flush = jump_acc | (~rst & (state != ST_RUN));

    always_comb begin
        for (int s = 0; s < NSTAGE; s++) begin
            jump_mask[s]  = (s >= 1) && (s <= JUMP_LVL);
            stall_base[s] = (LVL_W'(s) < lvl_sat);
            flush_base[s] = (s != 0) && (LVL_W'(s) == lvl_sat);
        end
    end

    // Flush wins over stall on the stages younger than the jumping one.
    assign stall_out     = force_flush ? (stall_base & ~jump_mask) : stall_base;
    assign flush_out     = force_flush ? (flush_base | jump_mask) : flush_base;
    assign hold_flag_out = |stall_out;
    assign jump_flag_out = issue;
    assign jump_addr_out = issue ? (jump_acc ? jump_addr_in : pend_addr) : '0;
    assign jump_pend_out = ~rst & (state == ST_PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            pend_addr <= '0;
            flush_cnt <= '0;
        end else if (jump_acc && held) begin
            state     <= ST_PEND;
            pend_addr <= jump_addr_in;
        end else if (issue) begin
            if (FLUSH_CYC > 0) begin
                state     <= ST_FLUSH;
                flush_cnt <= FC_W'(FLUSH_CYC);
            end else begin
                state <= ST_RUN;
            end
        end else if (state == ST_FLUSH) begin
            if (flush_cnt <= FC_W'(1)) begin
                state <= ST_RUN;
            end else begin
                flush_cnt <= flush_cnt - FC_W'(1);
            end
        end
    end

`ifdef CORE_PIPE_CTRL_WDT_EN
    localparam int WDT_W = $clog2(WDT_MAX + 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_trip;
    logic             wdt_hit;

    // wdt_cnt holds the held cycles before this one, so the trip shows during the WDT_MAX-th held cycle.
    assign wdt_hit = held && (wdt_cnt >= WDT_W'(WDT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt  <= '0;
            wdt_trip <= 1'b0;
        end else begin
            if (!held) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt != WDT_W'(WDT_MAX)) begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
            if (wdt_hit) begin
                wdt_trip <= 1'b1;
            end
        end
    end

    assign hold_wdt_out = ~rst & (wdt_trip | wdt_hit);
`else
    assign hold_wdt_out = 1'b0;
`endif

endmodule
